// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron layer: FSM state encoding,
// default widths and a width-parametrised saturating adder.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    TAIL  = 3'd2,
    FIRE  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam int SNN_N_NEURONS  = 16;
  localparam int SNN_N_INPUTS   = 16;
  localparam int SNN_W_WIDTH    = 8;
  localparam int SNN_POT_WIDTH  = 16;
  localparam int SNN_LEAK_SHIFT = 3;

  // Operands are sign-extended into 64 bits; the sum is clamped to a signed 'width'-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      sat_add = hi;
    end else if (s < lo) begin
      sat_add = lo;
    end else begin
      sat_add = s;
    end
  endfunction

endpackage

// File: rtl/snn_weight_ram.sv
// Weight store for the layer: 1R1W synchronous RAM, read-before-write, no reset.
module snn_weight_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // A same-address write lands after the read samples, so the read sees old data.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/snn_layer.sv
// Integrate-and-fire neuron layer sharing one weight RAM; fired indices are streamed lowest-first.
// Optional per-timestep leak is enabled by defining SNN_LAYER_LEAK_EN.
module snn_layer
  import snn_pkg::*;
#(
  parameter int N_NEURONS  = SNN_N_NEURONS,
  parameter int N_INPUTS   = SNN_N_INPUTS,
  parameter int W_WIDTH    = SNN_W_WIDTH,
  parameter int POT_WIDTH  = SNN_POT_WIDTH,
  parameter int LEAK_SHIFT = SNN_LEAK_SHIFT
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [$clog2(N_INPUTS)-1:0]            in_addr,
  input  logic                                   wr_en,
  input  logic [$clog2(N_INPUTS*N_NEURONS)-1:0]  wr_addr,
  input  logic [W_WIDTH-1:0]                     wr_data,
  input  logic [POT_WIDTH-1:0]                   threshold,
  input  logic                                   leak_tick,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(N_NEURONS)-1:0]           out_addr,
  output logic                                   busy
);

  localparam int AW_N  = $clog2(N_NEURONS);
  localparam int AW_IN = $clog2(N_INPUTS);

  state_e                      state_q, state_d;
  logic [AW_IN-1:0]            addr_q, addr_d;
  logic [AW_N-1:0]             k_q, k_d;
  logic [N_NEURONS-1:0]        pend_q, pend_d;
  logic signed [POT_WIDTH-1:0] pot_q [N_NEURONS];
  logic signed [POT_WIDTH-1:0] pot_d [N_NEURONS];
  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;
  logic [AW_N-1:0]             out_addr_q, out_addr_d;
  logic                        busy_q, busy_d;
  logic [W_WIDTH-1:0]          rd_data_s;
  logic [AW_N-1:0]             acc_idx_s;
  logic                        leak_block_s;

  function automatic logic [AW_N-1:0] lowest_set(input logic [N_NEURONS-1:0] v);
    lowest_set = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_set = AW_N'(i);
      end else begin
        lowest_set = lowest_set;
      end
    end
  endfunction

  snn_weight_ram #(
    .ADDR_W(AW_IN + AW_N),
    .DATA_W(W_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr ({addr_q, k_q}),
    .rd_data (rd_data_s)
  );

  // k wraps to 0 after the last read, so k-1 names the neuron whose weight just arrived.
  assign acc_idx_s = k_q - AW_N'(1);

`ifdef SNN_LAYER_LEAK_EN
  logic leak_pend_q, leak_pend_d;
  assign leak_block_s = leak_pend_d;
`else
  logic unused_leak_tick_s;
  localparam int unused_leak_shift = LEAK_SHIFT;
  assign unused_leak_tick_s = leak_tick;
  assign leak_block_s = 1'b0;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    k_d         = k_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    for (int i = 0; i < N_NEURONS; i++) begin
      pot_d[i] = pot_q[i];
    end
`ifdef SNN_LAYER_LEAK_EN
    leak_pend_d = leak_pend_q | leak_tick;
`endif
    case (state_q)
      IDLE: begin
`ifdef SNN_LAYER_LEAK_EN
        if (leak_pend_q) begin
          for (int i = 0; i < N_NEURONS; i++) begin
            pot_d[i] = pot_q[i] - (pot_q[i] >>> LEAK_SHIFT);
          end
          leak_pend_d = leak_tick;
        end else
`endif
        if (in_valid && in_ready_q) begin
          addr_d  = in_addr;
          k_d     = '0;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        k_d = k_q + AW_N'(1);
        if (k_q != '0) begin
          pot_d[acc_idx_s] = POT_WIDTH'(sat_add(64'(pot_q[acc_idx_s]),
                                                64'($signed(rd_data_s)), POT_WIDTH));
        end else begin
          pot_d[acc_idx_s] = pot_q[acc_idx_s];
        end
        if (k_q == AW_N'(N_NEURONS - 1)) begin
          state_d = TAIL;
        end else begin
          state_d = READ;
        end
      end
      TAIL: begin
        pot_d[acc_idx_s] = POT_WIDTH'(sat_add(64'(pot_q[acc_idx_s]),
                                              64'($signed(rd_data_s)), POT_WIDTH));
        state_d = FIRE;
      end
      FIRE: begin
        for (int i = 0; i < N_NEURONS; i++) begin
          if (pot_q[i] >= $signed(threshold)) begin
            pend_d[i] = 1'b1;
            pot_d[i]  = '0;
          end else begin
            pend_d[i] = 1'b0;
          end
        end
        if (pend_d != '0) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
          out_addr_d  = lowest_set(pend_d);
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pend_d[out_addr_q] = 1'b0;
          if (pend_d == '0) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            out_addr_d = lowest_set(pend_d);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE) && !leak_block_s;
    busy_d     = (state_d != IDLE);
  end

  // State, potentials and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      k_q         <= '0;
      pend_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot_q[i] <= pot_d[i];
      end
    end
  end

`ifdef SNN_LAYER_LEAK_EN
  // Ticks collapse into one pending leak until an IDLE cycle consumes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      leak_pend_q <= 1'b0;
    end else begin
      leak_pend_q <= leak_pend_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_snn_layer.sv
// Randomised bench for snn_layer against an event-level reference model
// (whole-event potential update, fire list, drain order and latency).
module tb_snn_layer;

  localparam int NN = 16;
  localparam int NI = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_addr = 4'd0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [15:0] threshold = 16'd0;
  logic        leak_tick = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_addr;
  logic        busy;

  int wm [NI][NN];
  int pm [NN];
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  snn_layer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .threshold (threshold),
    .leak_tick (leak_tick),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_w(input int row, input int col, input int val);
    wr_en = 1'b1;
    wr_addr = 8'(row * NN + col);
    wr_data = 8'(val);
    step();
    wr_en = 1'b0;
    wm[row][col] = val;
  endtask

  task automatic apply_leak();
    for (int i = 0; i < NN; i++) pm[i] = pm[i] - (pm[i] >>> 3);
  endtask

  // rmode: 0 = out_ready high, 1 = toggling, 2 = random. inject rewrites the row while it is read.
  task automatic run_event(input int addr, input int thr, input int rmode,
                           input bit inject, input bit tick);
    int exp_q[$];
    int neww[NN];
    int c;
    int r;
    bit stalled;
    int prev_addr;
    for (int i = 0; i < NN; i++) begin
      pm[i] = sat16(pm[i] + wm[addr][i]);
      if (pm[i] >= thr) begin
        exp_q.push_back(i);
        pm[i] = 0;
      end
      neww[i] = int'($urandom_range(255, 0)) - 128;
    end
    if (tick) apply_leak();
    threshold = 16'(thr);
    in_addr = 4'(addr);
    in_valid = 1'b1;
    c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      step();
      c++;
    end
    check_eq("accept_wait", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("busy", busy, 1);
    c = 0;
    while (c < 40 && out_valid !== 1'b1 && in_ready !== 1'b1) begin
      wr_en = inject && (c < NN);
      wr_addr = 8'(addr * NN + (c % NN));
      wr_data = 8'(neww[c % NN]);
      leak_tick = tick && (c == 3);
      step();
      c++;
    end
    wr_en = 1'b0;
    leak_tick = 1'b0;
    if (inject) for (int j = 0; j < NN; j++) wm[addr][j] = neww[j];
    if (exp_q.size() == 0) begin
      check_eq("idle_latency", c, NN + 2 + int'(tick));
      check_eq("no_fire_valid", out_valid, 0);
      return;
    end
    check_eq("fire_latency", c, NN + 2);
    c = 0;
    stalled = 1'b0;
    prev_addr = 0;
    while (exp_q.size() > 0 && c < 200) begin
      check_eq("out_valid", out_valid, 1);
      if (stalled) check_eq("addr_hold", out_addr, prev_addr);
      check_eq("out_addr", out_addr, exp_q[0]);
      r = (rmode == 0) ? 1 : (rmode == 1) ? int'(c % 2 == 0) : int'($urandom_range(1, 0));
      out_ready = r[0];
      prev_addr = int'(out_addr);
      stalled = (r == 0);
      step();
      c++;
      if (r != 0) void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    check_eq("drain_left", exp_q.size(), 0);
    check_eq("valid_low", out_valid, 0);
    if (tick) begin
      check_eq("leak_hold", in_ready, 0);
      step();
    end
    check_eq("ready_back", in_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < NN; i++) pm[i] = 0;
    #12;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr", out_addr, 0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("idle_ready", in_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_valid", out_valid, 0);

    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NN; j++) write_w(i, j, 0);

    // Directed weights, then an event aborted by reset part-way through READ.
    write_w(3, 5, 100);
    write_w(3, 9, 60);
    in_addr = 4'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check_eq("mid_read_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valid", out_valid, 0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("abort_ready", in_ready, 1);
    for (int i = 0; i < NN; i++) pm[i] = 0;

    run_event(3, 100, 0, 1'b0, 1'b0);
    run_event(3, 100, 0, 1'b0, 1'b0);
    // Every neuron fires with the minimum threshold.
    run_event(0, -32768, 1, 1'b0, 1'b0);

    write_w(4, 0, 127);
    write_w(4, 1, -128);
    for (int e = 0; e < 300; e++) run_event(4, 32767, 0, 1'b0, 1'b0);
    write_w(5, 1, 127);
    run_event(5, -32640, 0, 1'b0, 1'b0);

    for (int j = 0; j < NN; j++) write_w(2, j, int'($urandom_range(255, 0)) - 128);
    run_event(2, 50, 0, 1'b1, 1'b0);
    run_event(2, 50, 2, 1'b0, 1'b0);

    for (int e = 0; e < 40; e++) begin
      repeat ($urandom_range(3, 0))
        write_w(int'($urandom_range(NI - 1, 0)), int'($urandom_range(NN - 1, 0)),
                int'($urandom_range(255, 0)) - 128);
      run_event(int'($urandom_range(NI - 1, 0)), int'($urandom_range(500, 0)) - 200,
                int'($urandom_range(2, 0)), ($urandom_range(4, 0) == 0), 1'b0);
    end

`ifdef SNN_LAYER_LEAK_EN
    for (int e = 0; e < 8; e++) begin
      leak_tick = 1'b1;
      step();
      leak_tick = 1'b0;
      check_eq("tick_block", in_ready, 0);
      step();
      check_eq("tick_done", in_ready, 1);
      apply_leak();
      run_event(int'($urandom_range(NI - 1, 0)), int'($urandom_range(300, 0)),
                int'($urandom_range(2, 0)), 1'b0, (e % 2 == 1));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_layer.md
Name: snn_layer

Overview:
Parametrised spiking-neuron layer: N_NEURONS integrate-and-fire neurons sharing one on-chip weight RAM of N_INPUTS x N_NEURONS signed weights.
- Accepts input spike events over a valid/ready handshake and accumulates the addressed weight row into per-neuron membrane potentials.
- Fires every neuron at or above threshold and streams fired neuron indices out lowest-first over a valid/ready handshake.
- Successor to the fixed 16x16 PE array; sits between the sensor event FIFO and the next layer or output FIFO.

Parameters:
N_NEURONS, 16, neuron count; power of two, >= 2.
N_INPUTS, 16, input event address space; power of two, >= 2.
W_WIDTH, 8, signed weight width.
POT_WIDTH, 16, signed membrane potential width; must exceed W_WIDTH.
LEAK_SHIFT, 3, leak divisor exponent; used only with SNN_LAYER_LEAK_EN.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
in_valid  in  1  input event present.
in_ready  out  1  layer can accept an event.
in_addr  in  clog2(N_INPUTS)  input neuron index.
wr_en  in  1  weight write strobe.
wr_addr  in  clog2(N_INPUTS*N_NEURONS)  weight address, {input, neuron}.
wr_data  in  W_WIDTH  signed weight.
threshold  in  POT_WIDTH  signed firing threshold; sampled in FIRE.
leak_tick  in  1  timestep pulse; ignored unless SNN_LAYER_LEAK_EN.
out_valid  out  1  fired-neuron index valid.
out_ready  in  1  downstream accepts index.
out_addr  out  clog2(N_NEURONS)  fired neuron index.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all potentials 0; pending spike vector 0; out_valid=0, out_addr=0, busy=0, in_ready=1 once reset_n deasserts. Weight RAM is not reset and retains its contents.
- Reset mid-operation aborts everything; any event in flight is lost.
- FSM states: IDLE, READ, TAIL, FIRE, DRAIN.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_addr and go to READ with neuron counter k=0.
- READ (N_NEURONS cycles):
  - RAM read address = {latched addr, k}; k increments each cycle.
  - RAM read latency is 1 cycle; the data for k is accumulated into pot[k] in the following cycle.
  - After k=N_NEURONS-1, go to TAIL.
- TAIL: accumulate the last neuron; go to FIRE.
- FIRE:
  - pending[i] = (pot[i] >= threshold), signed compare.
  - Every fired pot[i] is set to 0.
  - If pending != 0, go to DRAIN; else go to IDLE.
- DRAIN:
  - out_valid=1; out_addr = lowest set index of pending.
  - On out_valid&&out_ready, clear that bit. When the last bit clears, go to IDLE in the same cycle.
  - out_addr is held stable while out_valid=1 and out_ready=0.
- Latency: first out_valid occurs N_NEURONS+2 cycles after the acceptance edge. With no spikes, in_ready returns N_NEURONS+2 cycles after acceptance.
- Arithmetic:
  - Weights are sign-extended to POT_WIDTH.
  - Sums saturate to the signed POT_WIDTH max/min; no wrap-around.
- Weight writes:
  - Accepted in any state, one per cycle.
  - Write and read to the same address in the same cycle returns the old data (read-before-write).
  - The new weight is used from the next event onward.
- in_valid held while not IDLE is not consumed; in_addr must stay stable until acceptance.

Optional Feature:
SNN_LAYER_LEAK_EN.
- Defined:
  - A leak_tick sampled in IDLE applies pot[i] <= pot[i] - (pot[i] >>> LEAK_SHIFT) to all neurons in one cycle.
  - in_ready=0 during that cycle; the tick has priority over in_valid.
  - A tick seen outside IDLE is latched and applied on the next IDLE cycle; multiple ticks collapse to one.
- Undefined: leak_tick is ignored; the leak logic is not synthesised.

Decomposition:
- Package snn_pkg holds:
  - state enum (IDLE, READ, TAIL, FIRE, DRAIN);
  - a sat_add function parametrised by width;
  - default width localparams.
- Sub-module snn_weight_ram: 1R1W synchronous RAM, read-before-write, no reset.
- The lowest-set-bit encoder is an in-module function.

Test Plan:
1. Reset then idle -> out_valid=0, busy=0, in_ready=1; reset_n pulsed mid-READ -> state IDLE, all pot=0, no out_valid.
2. Write w[3][5]=100, w[3][9]=60, threshold=100; event in_addr=3 -> out_valid 18 cycles after acceptance, out_addr=5 only. Second event in_addr=3 -> out_addr=9 (pot 120); neuron 5 fires again.
3. All 16 neurons fire, out_ready toggling 1/0 -> indices 0..15 in order, each exactly once, out_addr stable while stalled, then in_ready=1.
4. Weight 127 with threshold=32767, 300 events -> pot saturates at 32767 and fires; weight -128 repeated -> pot clamps at -32768, no wrap.
5. wr_en to {2,k} while processing event in_addr=2 -> current event uses old weights, next event uses new.
6. With SNN_LAYER_LEAK_EN, pot[0]=80, LEAK_SHIFT=3, leak_tick in IDLE -> pot[0]=70 and in_ready=0 that cycle; tick during READ -> applied on return to IDLE.
